// File: rtl/async_valid_sync_n.sv
// Multi-channel async level synchronizer with glitch filter, edge pulses
// and a sticky change-event mask behind a valid/ready handshake.
module async_valid_sync_n #(
  parameter int unsigned      WIDTH  = 4,
  parameter int unsigned      DEPTH  = 3,
  parameter int unsigned      FILTER = 0,
  parameter logic [WIDTH-1:0] INIT   = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall,
  output logic             io_evt_valid,
  input  logic             io_evt_ready,
  output logic [WIDTH-1:0] io_evt_bits,
  output logic             io_overrun,
  input  logic             io_overrun_clr
);

  localparam int unsigned CW =
    (FILTER > 0) ? $clog2(FILTER + 1) : 1;
  localparam logic [CW-1:0] FMAX = CW'(FILTER);

  logic [WIDTH-1:0] sync_q [DEPTH];
  logic [WIDTH-1:0] sync_d [DEPTH];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] toggle;
  logic             accept;

  always_comb begin
    sync_d[0] = io_in;
    for (int d = 1; d < DEPTH; d++) begin
      sync_d[d] = sync_q[d-1];
    end
    s = sync_q[DEPTH-1];

    out_d  = out_q;
    toggle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != out_q[i]) begin
        if (cnt_q[i] == FMAX) begin
          out_d[i]  = s[i];
          toggle[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    rise_d = toggle & out_d;
    fall_d = toggle & ~out_d;

    // A toggle landing on an accept edge starts the next mask.
    accept  = valid_q & io_evt_ready;
    pend_d  = accept ? toggle : (pend_q | toggle);
    valid_d = |pend_d;

    ovr_d = ovr_q;
    if (|(toggle & pend_q) && !accept) begin
      ovr_d = 1'b1;
    end else if (io_overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < DEPTH; d++) begin
        sync_q[d] <= INIT;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      out_q   <= INIT;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      for (int d = 0; d < DEPTH; d++) begin
        sync_q[d] <= sync_d[d];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign io_out       = out_q;
  assign io_rise      = rise_q;
  assign io_fall      = fall_q;
  assign io_evt_bits  = pend_q;
  assign io_evt_valid = valid_q;
  assign io_overrun   = ovr_q;

endmodule

// File: tb/tb_async_valid_sync_n.sv
// Randomized and directed bench for async_valid_sync_n against a
// sliding-window behavioural model.
module tb_async_valid_sync_n;

  localparam int W = 4;
  localparam int D = 3;
  localparam int F = 2;
  localparam int LAT = D + F + 1;
  localparam logic [W-1:0] INIT = '0;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] io_in = '0;
  logic [W-1:0] io_out, io_rise, io_fall, io_evt_bits;
  logic         io_evt_valid, io_overrun;
  logic         io_evt_ready = 1'b0;
  logic         io_overrun_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  async_valid_sync_n #(
    .WIDTH(W), .DEPTH(D), .FILTER(F), .INIT(INIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_in(io_in),
    .io_out(io_out),
    .io_rise(io_rise),
    .io_fall(io_fall),
    .io_evt_valid(io_evt_valid),
    .io_evt_ready(io_evt_ready),
    .io_evt_bits(io_evt_bits),
    .io_overrun(io_overrun),
    .io_overrun_clr(io_overrun_clr)
  );

  always #5 clock = ~clock;

  // Model: io_in delayed D edges, then io_out follows once the last
  // F+1 synchronized samples all agree.
  logic [W-1:0] m_sh  [D];
  logic [W-1:0] m_win [F+1];
  logic [W-1:0] m_out, m_rise, m_fall, m_pend;
  logic         m_valid, m_ovr;

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_sh[i] = INIT;
    for (int i = 0; i <= F; i++) m_win[i] = INIT;
    m_out = INIT;
    m_rise = '0;
    m_fall = '0;
    m_pend = '0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic model_edge();
    logic [W-1:0] all1, all0, nout, tog;
    bit acc;
    for (int i = F; i > 0; i--) m_win[i] = m_win[i-1];
    m_win[0] = m_sh[D-1];
    for (int i = D - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
    m_sh[0] = io_in;
    all1 = '1;
    all0 = '1;
    for (int i = 0; i <= F; i++) begin
      all1 &= m_win[i];
      all0 &= ~m_win[i];
    end
    nout = all1 | (m_out & ~all0);
    tog = nout ^ m_out;
    acc = m_valid && io_evt_ready;
    if (((tog & m_pend) != '0) && !acc) m_ovr = 1'b1;
    else if (io_overrun_clr) m_ovr = 1'b0;
    m_pend = acc ? tog : (m_pend | tog);
    m_valid = (m_pend != '0);
    m_rise = tog & nout;
    m_fall = tog & ~nout;
    m_out = nout;
  endtask

  task automatic cyc();
    @(posedge clock);
    if (reset) model_edge();
    else model_reset();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    cyc();
    vectors++;
    if ({io_out, io_rise, io_fall, io_evt_bits, io_evt_valid, io_overrun}
        !== {INIT, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: out=%h rise=%h fall=%h bits=%h v=%b ovr=%b",
               io_out, io_rise, io_fall, io_evt_bits, io_evt_valid,
               io_overrun);
    end
    reset = 1'b1;
  endtask

  task automatic test_latency();
    io_in = 4'b0101;
    for (int k = 1; k <= LAT + 2; k++) begin
      cyc();
      vectors++;
      if ({io_out, io_rise, io_fall, io_evt_valid, io_evt_bits, io_overrun}
          !== {m_out, m_rise, m_fall, m_valid, m_pend, m_ovr}) begin
        miscompares++;
        $display("FAIL latency_model k=%0d: out=%h rise=%h bits=%h exp %h %h %h",
                 k, io_out, io_rise, io_evt_bits, m_out, m_rise, m_pend);
      end
      if (k < LAT) begin
        vectors++;
        if (io_out !== 4'b0000) begin
          miscompares++;
          $display("FAIL latency_early k=%0d: out=%h exp 0", k, io_out);
        end
      end else if (k == LAT) begin
        vectors++;
        if ({io_out, io_rise, io_evt_bits} !== {3{4'b0101}}) begin
          miscompares++;
          $display("FAIL latency_edge: out=%h rise=%h bits=%h exp 0101",
                   io_out, io_rise, io_evt_bits);
        end
      end
    end
  endtask

  task automatic test_filter();
    io_evt_ready = 1'b1;
    io_in = '0;
    for (int k = 0; k < 12; k++) cyc();
    io_in[0] = 1'b1;
    cyc();
    cyc();
    io_in[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      vectors++;
      if ({io_out[0], io_rise[0], io_evt_bits[0]} !== 3'b000 ||
          {io_out, io_rise, io_fall, io_evt_valid, io_evt_bits}
          !== {m_out, m_rise, m_fall, m_valid, m_pend}) begin
        miscompares++;
        $display("FAIL filter_glitch k=%0d: out=%h rise=%h bits=%h exp %h",
                 k, io_out, io_rise, io_evt_bits, m_out);
      end
    end
    io_in[0] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      if (k == 5) io_in[0] = 1'b0;
      cyc();
      vectors++;
      if ({io_out, io_rise, io_fall, io_evt_valid, io_evt_bits, io_overrun}
          !== {m_out, m_rise, m_fall, m_valid, m_pend, m_ovr}) begin
        miscompares++;
        $display("FAIL filter_pulse k=%0d: out=%h rise=%h fall=%h exp %h %h %h",
                 k, io_out, io_rise, io_fall, m_out, m_rise, m_fall);
      end
      vectors++;
      if (io_rise[0] !== (k == LAT) || io_fall[0] !== (k == LAT + 4)) begin
        miscompares++;
        $display("FAIL filter_edge k=%0d: rise0=%b fall0=%b", k,
                 io_rise[0], io_fall[0]);
      end
    end
  endtask

  task automatic test_handshake();
    io_in = '0;
    io_evt_ready = 1'b1;
    for (int k = 0; k < 10; k++) cyc();
    io_evt_ready = 1'b0;
    io_in[1] = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    io_in[2] = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    vectors++;
    if ({io_evt_valid, io_evt_bits} !== {1'b1, 4'b0110}) begin
      miscompares++;
      $display("FAIL hs_hold: v=%b bits=%h exp 1 0110",
               io_evt_valid, io_evt_bits);
    end
    io_evt_ready = 1'b1;
    cyc();
    io_evt_ready = 1'b0;
    vectors++;
    if ({io_evt_valid, io_evt_bits} !== {1'b0, 4'b0000} ||
        {io_evt_valid, io_evt_bits} !== {m_valid, m_pend}) begin
      miscompares++;
      $display("FAIL hs_accept: v=%b bits=%h exp 0 0000",
               io_evt_valid, io_evt_bits);
    end
  endtask

  task automatic test_coincident();
    io_overrun_clr = 1'b1;
    cyc();
    io_overrun_clr = 1'b0;
    io_in[1] = 1'b0;
    for (int k = 0; k < 8; k++) cyc();
    io_in[3] = 1'b1;
    for (int k = 0; k < LAT - 1; k++) cyc();
    io_evt_ready = 1'b1;
    cyc();
    io_evt_ready = 1'b0;
    vectors++;
    if ({io_evt_bits, io_evt_valid, io_overrun} !== {4'b1000, 1'b1, 1'b0} ||
        {io_evt_bits, io_evt_valid, io_overrun}
        !== {m_pend, m_valid, m_ovr}) begin
      miscompares++;
      $display("FAIL coincident: bits=%h v=%b ovr=%b exp 1000 1 0",
               io_evt_bits, io_evt_valid, io_overrun);
    end
  endtask

  task automatic test_overrun();
    io_evt_ready = 1'b0;
    io_in[0] = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    io_in[0] = 1'b0;
    for (int k = 0; k < 8; k++) cyc();
    vectors++;
    if (io_overrun !== 1'b1 || io_overrun !== m_ovr) begin
      miscompares++;
      $display("FAIL ovr_set: ovr=%b exp 1", io_overrun);
    end
    io_in[0] = 1'b1;
    for (int k = 0; k < LAT - 1; k++) cyc();
    io_overrun_clr = 1'b1;
    cyc();
    vectors++;
    if (io_overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_priority: ovr=%b exp 1", io_overrun);
    end
    cyc();
    io_overrun_clr = 1'b0;
    vectors++;
    if (io_overrun !== 1'b0 || io_overrun !== m_ovr) begin
      miscompares++;
      $display("FAIL ovr_clear: ovr=%b exp 0", io_overrun);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) io_in[b] = ~io_in[b];
      io_evt_ready = ($urandom_range(0, 3) == 0);
      io_overrun_clr = ($urandom_range(0, 7) == 0);
      cyc();
      vectors++;
      if ({io_out, io_rise, io_fall, io_evt_valid, io_evt_bits, io_overrun}
          !== {m_out, m_rise, m_fall, m_valid, m_pend, m_ovr}) begin
        miscompares++;
        $display("FAIL random k=%0d: o=%h r=%h f=%h v=%b b=%h ov=%b exp %h %h %h %b %h %b",
                 k, io_out, io_rise, io_fall, io_evt_valid, io_evt_bits,
                 io_overrun, m_out, m_rise, m_fall, m_valid, m_pend, m_ovr);
      end
    end
    io_evt_ready = 1'b0;
    io_overrun_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    int n;
    io_evt_ready = 1'b0;
    io_in = '0;
    for (int k = 0; k < 10; k++) cyc();
    io_in = 4'b0001;
    for (int k = 0; k < 10; k++) cyc();
    io_in = 4'b1111;
    for (int k = 0; k < D + 1; k++) cyc();
    vectors++;
    if (io_evt_valid !== 1'b1 || io_evt_bits === 4'b0000) begin
      miscompares++;
      $display("FAIL areset_pre: v=%b bits=%h exp pending",
               io_evt_valid, io_evt_bits);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({io_out, io_rise, io_fall, io_evt_valid, io_evt_bits, io_overrun}
        !== {INIT, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL areset_async: o=%h r=%h f=%h v=%b b=%h ov=%b",
               io_out, io_rise, io_fall, io_evt_valid, io_evt_bits,
               io_overrun);
    end
    model_reset();
    cyc();
    reset = 1'b1;
    n = 0;
    while (io_out !== 4'b1111 && n < 20) begin
      cyc();
      n++;
      vectors++;
      if ({io_out, io_rise, io_evt_valid, io_evt_bits}
          !== {m_out, m_rise, m_valid, m_pend}) begin
        miscompares++;
        $display("FAIL areset_model n=%0d: o=%h r=%h b=%h exp %h %h %h",
                 n, io_out, io_rise, io_evt_bits, m_out, m_rise, m_pend);
      end
    end
    vectors++;
    if (n !== LAT || io_evt_bits !== 4'b1111 || io_rise !== 4'b1111) begin
      miscompares++;
      $display("FAIL areset_latency: edges=%0d exp %0d bits=%h rise=%h",
               n, LAT, io_evt_bits, io_rise);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    test_reset();
    test_latency();
    test_filter();
    test_handshake();
    test_coincident();
    test_overrun();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
